ifid_skid_buffer: RTL and testbench

//  Fetch-to-decode pipeline buffer of the 16-bit processor. Accepts fetched instruction/PC pairs

---
 rtl/ifid_skid_buffer_pkg.sv | 25 ++
 rtl/ifid_skid_buffer_if.sv | 28 ++
 rtl/ifid_entry_reg.sv | 24 ++
 rtl/ifid_skid_buffer.sv | 94 +++++++++
 tb/tb_ifid_skid_buffer.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/ifid_skid_buffer_pkg.sv
// Shared definitions for the fetch-to-decode buffer: field widths, opcodes, buffer state encoding.
package ifid_skid_buffer_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned PC_W    = 16;
    localparam int unsigned OP_W    = 3;
    localparam int unsigned IMM_W   = 13;

    localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
    localparam logic [OP_W-1:0] OP_ADDI = 3'b001;
    localparam logic [OP_W-1:0] OP_NAND = 3'b010;
    localparam logic [OP_W-1:0] OP_LUI  = 3'b011;
    localparam logic [OP_W-1:0] OP_SW   = 3'b100;
    localparam logic [OP_W-1:0] OP_LW   = 3'b101;
    localparam logic [OP_W-1:0] OP_BEQ  = 3'b110;
    localparam logic [OP_W-1:0] OP_JALR = 3'b111;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } ifid_state_e;

endpackage

// File: rtl/ifid_skid_buffer_if.sv
// Fetch-side and decode-side handshake bundle of the IF/ID buffer.
interface ifid_skid_buffer_if;
    import ifid_skid_buffer_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic [PC_W-1:0]    in_pc;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [OP_W-1:0]    out_opcode;
    logic [IMM_W-1:0]   out_imm;
    logic [PC_W-1:0]    out_pc;
    logic [1:0]         occupancy;

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_instr, out_opcode, out_imm, out_pc, occupancy
    );

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_instr, out_opcode, out_imm, out_pc, occupancy
    );

endinterface

// File: rtl/ifid_entry_reg.sv
// One buffer slot: an {instr, pc} register with load enable and asynchronous clear.
module ifid_entry_reg
    import ifid_skid_buffer_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [INSTR_W-1:0] d_instr,
    input  logic [PC_W-1:0]    d_pc,
    output logic [INSTR_W-1:0] q_instr,
    output logic [PC_W-1:0]    q_pc
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_instr <= '0;
            q_pc    <= '0;
        end else if (load) begin
            q_instr <= d_instr;
            q_pc    <= d_pc;
        end
    end

endmodule

// File: rtl/ifid_skid_buffer.sv
// Two-entry IF/ID skid buffer; head register drives decode directly, in_ready is registered-only.
module ifid_skid_buffer
    import ifid_skid_buffer_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    ifid_skid_buffer_if.slave  bus
);

    ifid_state_e        state_q, state_d;
    logic               push, pop;
    logic               head_load, tail_load, head_from_tail;
    logic [INSTR_W-1:0] head_instr, tail_instr, head_d_instr;
    logic [PC_W-1:0]    head_pc, tail_pc, head_d_pc;

    assign bus.in_ready  = (state_q != FULL);
    assign bus.out_valid = (state_q != EMPTY);
    assign bus.occupancy = state_q;

    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    // Flush wins over push/pop; held registers keep their contents so outputs hold.
    always_comb begin
        state_d        = state_q;
        head_load      = 1'b0;
        tail_load      = 1'b0;
        head_from_tail = 1'b0;
        if (bus.flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        head_load = 1'b1;
                        state_d   = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_load = 1'b1;
                    end else if (push) begin
                        tail_load = 1'b1;
                        state_d   = FULL;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_load      = 1'b1;
                        head_from_tail = 1'b1;
                        state_d        = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    assign head_d_instr = head_from_tail ? tail_instr : bus.in_instr;
    assign head_d_pc    = head_from_tail ? tail_pc    : bus.in_pc;

    ifid_entry_reg u_head (
        .clk     (clk),
        .reset   (reset),
        .load    (head_load),
        .d_instr (head_d_instr),
        .d_pc    (head_d_pc),
        .q_instr (head_instr),
        .q_pc    (head_pc)
    );

    ifid_entry_reg u_tail (
        .clk     (clk),
        .reset   (reset),
        .load    (tail_load),
        .d_instr (bus.in_instr),
        .d_pc    (bus.in_pc),
        .q_instr (tail_instr),
        .q_pc    (tail_pc)
    );

    assign bus.out_instr  = head_instr;
    assign bus.out_pc     = head_pc;
    assign bus.out_opcode = head_instr[INSTR_W-1 -: OP_W];
    assign bus.out_imm    = head_instr[IMM_W-1:0];

endmodule

// File: tb/tb_ifid_skid_buffer.sv
// Scoreboard bench for ifid_skid_buffer: directed scenarios plus randomized valid/ready/flush traffic.
module tb_ifid_skid_buffer;
    import ifid_skid_buffer_pkg::*;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
    } word_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    word_t exp_q[$];
    word_t last;

    ifid_skid_buffer_if bus ();

    ifid_skid_buffer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Acceptance is decided from the model's held count, sampled before this cycle's pop.
    task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                         input logic rdy, input logic fl);
        logic  acc;
        word_t w;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_instr  = ins;
        bus.in_pc     = pc;
        bus.out_ready = rdy;
        bus.flush     = fl;
        acc = v && (exp_q.size() < 2) && !fl;
        #2;
        if (acc) begin
            w.instr = ins;
            w.pc    = pc;
            exp_q.push_back(w);
        end
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 16'h0, 16'h0, rdy, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        #3 reset = 1'b1;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_occupancy", 32'(bus.occupancy), 32'd0);
        check("rst_out_instr", 32'(bus.out_instr), 32'd0);
        check("rst_out_pc", 32'(bus.out_pc), 32'd0);
        exp_q.delete();
        last = '0;
        @(negedge clk);
        #3 reset = 1'b0;
    endtask

    // Monitor: compares the presented head against the scoreboard every cycle.
    initial begin
        word_t front;
        forever begin
            @(negedge clk);
            #1;
            if (!reset) begin
                check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() > 0));
                check("in_ready", 32'(bus.in_ready), 32'(exp_q.size() < 2));
                check("occupancy", 32'(bus.occupancy), 32'(exp_q.size()));
                if (exp_q.size() > 0) begin
                    front = exp_q[0];
                    check("out_instr", 32'(bus.out_instr), 32'(front.instr));
                    check("out_pc", 32'(bus.out_pc), 32'(front.pc));
                    check("out_opcode", 32'(bus.out_opcode), 32'(front.instr) >> 13);
                    check("out_imm", 32'(bus.out_imm), 32'(front.instr) % 8192);
                    last = front;
                    if (bus.out_ready && !bus.flush) void'(exp_q.pop_front());
                end else begin
                    check("hold_instr", 32'(bus.out_instr), 32'(last.instr));
                    check("hold_pc", 32'(bus.out_pc), 32'(last.pc));
                end
                if (bus.flush) exp_q.delete();
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        checks        = 0;
        errors        = 0;
        last          = '0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        do_reset();

        // Single push, one-cycle latency, field split.
        drive(1'b1, 16'hA00B, 16'h0004, 1'b1, 1'b0);
        idle(1'b1);
        check("single_valid", 32'(bus.out_valid), 32'd1);
        check("single_opcode", 32'(bus.out_opcode), 32'(OP_LW));
        check("single_imm", 32'(bus.out_imm), 32'h000B);
        check("single_pc", 32'(bus.out_pc), 32'h0004);
        idle(1'b1);
        check("single_drained", 32'(bus.out_valid), 32'd0);

        // Stall fills both entries, then drains in order.
        drive(1'b1, 16'h1FFF, 16'h0010, 1'b0, 1'b0);
        drive(1'b1, 16'h2001, 16'h0011, 1'b0, 1'b0);
        idle(1'b0);
        check("stall_occupancy", 32'(bus.occupancy), 32'd2);
        check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        check("stall_imm", 32'(bus.out_imm), 32'h1FFF);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        check("stall_drained", 32'(bus.out_valid), 32'd0);

        // Streaming at one word per cycle.
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 16'(k), 16'(k), 1'b1, 1'b0);
            if (k == 3) check("stream_occupancy", 32'(bus.occupancy), 32'd1);
        end
        idle(1'b1);
        idle(1'b1);

        // Flush while FULL with a pending push, then flush in ONE with push and pop.
        drive(1'b1, 16'hAAAA, 16'h0020, 1'b0, 1'b0);
        drive(1'b1, 16'hBBBB, 16'h0021, 1'b0, 1'b0);
        drive(1'b1, 16'hCCCC, 16'h0022, 1'b0, 1'b1);
        idle(1'b1);
        check("flush_full_valid", 32'(bus.out_valid), 32'd0);
        check("flush_full_occupancy", 32'(bus.occupancy), 32'd0);
        drive(1'b1, 16'hDDDD, 16'h0023, 1'b0, 1'b0);
        drive(1'b1, 16'hEEEE, 16'h0024, 1'b1, 1'b1);
        idle(1'b1);
        check("flush_one_valid", 32'(bus.out_valid), 32'd0);
        check("flush_one_hold", 32'(bus.out_instr), 32'hDDDD);
        idle(1'b1);

        // Reset while holding two entries.
        drive(1'b1, 16'h1234, 16'h0030, 1'b0, 1'b0);
        drive(1'b1, 16'h5678, 16'h0031, 1'b0, 1'b0);
        idle(1'b0);
        check("pre_reset_occupancy", 32'(bus.occupancy), 32'd2);
        do_reset();
        idle(1'b1);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0));
        end
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        check("final_empty", 32'(bus.occupancy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
